// File: rtl/decode_stage.sv
// RV32I/M decode stage with a two-entry skid buffer.
// Registered outputs; in_ready depends only on held state.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_we,
  output logic [2:0]      out_fn,
  output logic [3:0]      out_alu_fn,
  output logic [1:0]      out_b_sel,
  output logic [3:0]      out_mem_op,
  output logic [2:0]      out_muldiv_op,
  output logic            out_j,
  output logic            out_jr,
  output logic            out_btype,
  output logic            out_bneq,
  output logic            out_lui,
  output logic            out_auipc,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            we;
    logic [2:0]      fn;
    logic [3:0]      alu_fn;
    logic [1:0]      b_sel;
    logic [3:0]      mem_op;
    logic [2:0]      muldiv_op;
    logic            j;
    logic            jr;
    logic            btype;
    logic            bneq;
    logic            lui;
    logic            auipc;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  function automatic logic [XLEN-1:0] sext32(
    input logic signed [31:0] v
  );
    sext32 = XLEN'(v);
  endfunction

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign op    = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rd_f  = in_instr[11:7];
  assign rs1_f = in_instr[19:15];
  assign rs2_f = in_instr[24:20];

  assign imm_i = sext32({{20{in_instr[31]}}, in_instr[31:20]});
  assign imm_s = sext32({{20{in_instr[31]}}, in_instr[31:25],
                         in_instr[11:7]});
  assign imm_b = sext32({{19{in_instr[31]}}, in_instr[31],
                         in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0});
  assign imm_u = sext32({in_instr[31:12], 12'b0});
  assign imm_j = sext32({{11{in_instr[31]}}, in_instr[31],
                         in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0});

  bundle_t dec;
  logic    ok;
  logic    wr;

  // Combinational decode of the offered instruction.
  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    ok     = 1'b0;
    wr     = 1'b0;
    unique case (1'b1)
      (op == OP_LUI): begin
        ok      = 1'b1;
        wr      = 1'b1;
        dec.rd  = rd_f;
        dec.imm = imm_u;
        dec.fn  = 3'b011;
        dec.lui = 1'b1;
      end
      (op == OP_AUIPC): begin
        ok        = 1'b1;
        wr        = 1'b1;
        dec.rd    = rd_f;
        dec.imm   = imm_u;
        dec.fn    = 3'b100;
        dec.auipc = 1'b1;
      end
      (op == OP_JAL): begin
        ok      = 1'b1;
        wr      = 1'b1;
        dec.rd  = rd_f;
        dec.imm = imm_j;
        dec.fn  = 3'b001;
        dec.j   = 1'b1;
      end
      (op == OP_JALR): begin
        ok        = (f3 == 3'b000);
        wr        = 1'b1;
        dec.rd    = rd_f;
        dec.rs1   = rs1_f;
        dec.imm   = imm_i;
        dec.fn    = 3'b001;
        dec.b_sel = 2'b01;
        dec.jr    = 1'b1;
      end
      (op == OP_BRANCH): begin
        ok        = 1'b1;
        dec.rs1   = rs1_f;
        dec.rs2   = rs2_f;
        dec.imm   = imm_b;
        dec.btype = 1'b1;
        case (f3)
          3'b000:  dec.alu_fn = 4'b1000;
          3'b001: begin
            dec.alu_fn = 4'b1000;
            dec.bneq   = 1'b1;
          end
          3'b100:  dec.alu_fn = 4'b0010;
          3'b101:  dec.alu_fn = 4'b1001;
          3'b110:  dec.alu_fn = 4'b0011;
          3'b111:  dec.alu_fn = 4'b1010;
          default: ok = 1'b0;
        endcase
      end
      (op == OP_LOAD): begin
        ok        = 1'b1;
        wr        = 1'b1;
        dec.rd    = rd_f;
        dec.rs1   = rs1_f;
        dec.imm   = imm_i;
        dec.fn    = 3'b111;
        dec.b_sel = 2'b01;
        case (f3)
          3'b000:  dec.mem_op = 4'b0001;
          3'b001:  dec.mem_op = 4'b0010;
          3'b010:  dec.mem_op = 4'b0011;
          3'b100:  dec.mem_op = 4'b0100;
          3'b101:  dec.mem_op = 4'b0101;
          default: ok = 1'b0;
        endcase
      end
      (op == OP_STORE): begin
        ok        = 1'b1;
        dec.rs1   = rs1_f;
        dec.rs2   = rs2_f;
        dec.imm   = imm_s;
        dec.b_sel = 2'b01;
        case (f3)
          3'b000:  dec.mem_op = 4'b1110;
          3'b001:  dec.mem_op = 4'b1111;
          3'b010:  dec.mem_op = 4'b1000;
          default: ok = 1'b0;
        endcase
      end
      (op == OP_IMM): begin
        wr      = 1'b1;
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.imm = imm_i;
        case (f3)
          3'b001: begin
            ok         = (f7 == F7_BASE);
            dec.alu_fn = 4'b0001;
            dec.b_sel  = 2'b10;
          end
          3'b101: begin
            ok         = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec.alu_fn = in_instr[30] ? 4'b1101 : 4'b0101;
            dec.b_sel  = 2'b10;
          end
          default: begin
            ok         = 1'b1;
            dec.alu_fn = {1'b0, f3};
            dec.b_sel  = 2'b01;
          end
        endcase
      end
      (op == OP_REG): begin
        wr      = 1'b1;
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        if (f7 == F7_MUL) begin
          ok            = M_EXT;
          dec.fn        = 3'b010;
          dec.muldiv_op = f3;
        end else if (f7 == F7_BASE) begin
          ok         = 1'b1;
          dec.alu_fn = {1'b0, f3};
        end else if (f7 == F7_ALT) begin
          case (f3)
            3'b000: begin
              ok         = 1'b1;
              dec.alu_fn = 4'b1000;
            end
            3'b101: begin
              ok         = 1'b1;
              dec.alu_fn = 4'b1101;
            end
            default: ok = 1'b0;
          endcase
        end else begin
          ok = 1'b0;
        end
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end else begin
      dec.we = wr && (dec.rd != 5'd0);
    end
  end

  bundle_t m_q;
  bundle_t s_q;
  logic    m_valid;
  logic    s_valid;
  logic    accept;
  logic    leave;

  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign leave    = m_valid && out_ready;

  // Main/skid buffer update; flush drops everything held and offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (leave) begin
      if (s_valid) begin
        m_q     <= s_q;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_q <= dec;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (!m_valid) begin
      if (accept) begin
        m_q     <= dec;
        m_valid <= 1'b1;
      end
    end else if (accept) begin
      s_q     <= dec;
      s_valid <= 1'b1;
    end
  end

  assign out_valid     = m_valid;
  assign out_pc        = m_q.pc;
  assign out_rd        = m_q.rd;
  assign out_rs1       = m_q.rs1;
  assign out_rs2       = m_q.rs2;
  assign out_imm       = m_q.imm;
  assign out_we        = m_q.we;
  assign out_fn        = m_q.fn;
  assign out_alu_fn    = m_q.alu_fn;
  assign out_b_sel     = m_q.b_sel;
  assign out_mem_op    = m_q.mem_op;
  assign out_muldiv_op = m_q.muldiv_op;
  assign out_j         = m_q.j;
  assign out_jr        = m_q.jr;
  assign out_btype     = m_q.btype;
  assign out_bneq      = m_q.bneq;
  assign out_lui       = m_q.lui;
  assign out_auipc     = m_q.auipc;
  assign out_illegal   = m_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I/M instruction-decode stage between fetch and issue. It accepts one instruction per cycle over a valid/ready handshake and decodes it fully: control fields, register indices, sign-extended immediate, and illegal-instruction flag. A two-entry skid buffer lets fetch run at full rate without a combinational path from `out_ready` to `in_ready`. Supports a synchronous pipeline flush and build-time M-extension enable.

Parameters:
- XLEN, 32, datapath/PC/immediate width (32 or 64; immediates sign-extended to XLEN).
- M_EXT, 1, 1 = decode MUL/DIV/REM; 0 = those encodings flagged illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush  in  1  kill all held and incoming instructions
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  issue accepts bundle
- out_pc  out  XLEN  PC of bundle
- out_rd, out_rs1, out_rs2  out  5 each  register indices (0 when unused)
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J)
- out_we  out  1  regfile write-back
- out_fn  out  3  result select: 000 alu, 001 pc+4, 010 muldiv, 011 imm (LUI), 100 auipc, 111 load
- out_alu_fn  out  4  0000 add, 0001 sll, 0010 slt/blt, 0011 sltu/bltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1000 sub/beq/bne, 1001 bge, 1010 bgeu, 1101 sra
- out_b_sel  out  2  00 rs2, 01 imm, 10 shamt
- out_mem_op  out  4  0000 none, 0001 lb, 0010 lh, 0011 lw, 0100 lbu, 0101 lhu, 1110 sb, 1111 sh, 1000 sw
- out_muldiv_op  out  3  funct3 of M instruction
- out_j, out_jr, out_btype, out_bneq, out_lui, out_auipc  out  1 each  instruction class flags
- out_illegal  out  1  undefined encoding

Behaviour:
- Reset: both buffer entries invalid; `out_valid` = 0, every `out_*` bundle field = 0; `in_ready` = 1 in the first cycle after reset.
- Accept when `in_valid & in_ready`. Latency is 1 cycle: the bundle appears on `out_*` the cycle after accept.
- Buffer: main register M and skid register S.
  - `in_ready` = !S.valid. It is driven only by registered state.
  - Accept with M empty, or with M leaving this cycle (`out_valid & out_ready`): load M.
  - Accept with M held (`!out_ready`): load S.
  - When M leaves and S is valid: S moves to M and S clears.
  - Order is preserved.
- Bundle fields are stable while `out_valid & !out_ready`.
- Flush (highest priority): M and S are invalidated next cycle, and any same-cycle input is dropped even if `in_ready` = 1. `in_ready` = 1 next cycle.
- Decode rules:
  - Opcode must have `in_instr[1:0]` = 11.
  - rtype: add/sub and srl/sra are selected by bit 30. Any other bit-30 use is illegal. funct7 must be 0000000 or 0100000.
  - funct7 = 0000001 is M, and is legal only if M_EXT = 1: `out_fn` = 010, `out_muldiv_op` = funct3.
  - itype shifts: slli requires funct7 = 0; srli/srai funct7 = 0000000/0100000.
  - jalr requires funct3 = 000. Branch funct3 010/011 is illegal. Load funct3 011/110/111 is illegal. Store funct3 > 010 is illegal.
  - `out_bneq` = 1 only for BNE.
  - `out_b_sel` = 01 for itype non-shift, loads, stores, and jalr.
- `out_we` = 1 for rtype, itype, load, jal, jalr, lui, auipc, but only if `out_rd` ≠ 0 and the instruction is legal.
- Illegal bundle: `out_illegal` = 1; `out_we` = 0, `out_mem_op` = 0, all class flags = 0; `out_pc` still valid. It flows through the handshake like any other bundle.
- Immediate types:
  - I: lower 12 bits sign-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - No-immediate instructions: `out_imm` = 0.
- Register indices are zero when not used by the format (U/J: rs1 = rs2 = 0; I: rs2 = 0; S/B: rd = 0).

Test Plan:
- Reset then `addi x5,x1,-1` (0xFFF08293), `out_ready` = 1 → next cycle: `out_valid` = 1, `out_rd` = 5, `out_rs1` = 1, `out_imm` = 0xFFFFFFFF, `out_alu_fn` = 0000, `out_b_sel` = 01, `out_we` = 1.
- Streaming: hold `out_ready` = 0 for 3 cycles while `in_valid` = 1 → exactly 2 accepted, `in_ready` = 0 from the 3rd cycle. Release → both emerge in order and `in_ready` reasserts; no loss or duplication.
- Flush with M and S full plus `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1, and no flushed PC ever appears.
- M_EXT = 0, `mul x3,x1,x2` (0x022081B3) → `out_illegal` = 1, `out_we` = 0. With M_EXT = 1 → `out_fn` = 010, `out_muldiv_op` = 000.
- `sra x3,x1,x2` (0x4020D1B3) → `out_alu_fn` = 1101. `sw x2,-4(x1)` (0xFE20AE23) → `out_mem_op` = 1000, `out_imm` = 0xFFFFFFFC, `out_we` = 0.
- `jalr x1,0(x2)` with funct3 = 001 → `out_illegal` = 1. Legal jalr → `out_jr` = 1, `out_fn` = 001.
